// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM encodings and vector-count helper.
package tt_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle-delay counter: counts up while enabled, clears on request, flags the last settle cycle.
module tt_settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign term = (cnt == W'(SETTLE_CYC - 1));

endmodule

// File: rtl/truth_table_checker.sv
// On-chip exhaustive checker: sweeps every input vector, samples y_in after a settle delay,
// and compares against a golden table latched at start.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(2**N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       vec_out,
  input  logic                  y_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(2**N_IN)-1:0]  captured,
  output logic [N_IN:0]         mismatch_cnt,
  output logic                  fail_valid,
  output logic [N_IN-1:0]       first_fail
);

  localparam int NVEC = nvec(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("truth_table_checker: N_IN must be in 1..8");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("truth_table_checker: SETTLE_CYC must be >= 1");
  end

  logic [1:0]       state;
  logic [NVEC-1:0]  exp_q;
  logic             term;
  logic             y_mis;
  logic [N_IN:0]    mc_next;

  // Timer is held at zero outside SETTLE so each settle window starts fresh.
  tt_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != ST_SETTLE) || term),
    .en    (state == ST_SETTLE),
    .term  (term)
  );

  // Current-cycle count so a mismatch on the final vector still lands in pass.
  assign y_mis   = (y_in != exp_q[vec_out]);
  assign mc_next = mismatch_cnt + {{N_IN{1'b0}}, y_mis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      exp_q        <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      captured     <= '0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      first_fail   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q        <= expected;
            vec_out      <= '0;
            captured     <= '0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else if (term) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            captured[vec_out] <= y_in;
            mismatch_cnt      <= mc_next;
            if (y_mis && !fail_valid) begin
              fail_valid <= 1'b1;
              first_fail <= vec_out;
            end
            if (vec_out == VEC_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (mc_next == '0);
              state <= ST_DONE;
            end else begin
              vec_out <= vec_out + 1'b1;
              state   <= ST_SETTLE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: expected sweep results are queued at start and checked on each done pulse.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort;
  logic [7:0]  expected;
  logic [2:0]  vec_out;
  logic        y_in;
  logic        busy, done, pass, fail_valid;
  logic [7:0]  captured;
  logic [3:0]  mismatch_cnt;
  logic [2:0]  first_fail;

  logic        start4, abort4;
  logic [15:0] expected4;
  logic [3:0]  vec4;
  logic        y4;
  logic        busy4, done4, pass4, fail_valid4;
  logic [15:0] captured4;
  logic [4:0]  mismatch_cnt4;
  logic [3:0]  first_fail4;

  logic        use_rand;
  logic [7:0]  rand_tt;

  assign y_in = use_rand ? rand_tt[vec_out] : ((vec_out[2] & vec_out[1]) | ~vec_out[0]);
  assign y4   = ^vec4;

  truth_table_checker #(.N_IN(3), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .vec_out(vec_out), .y_in(y_in), .busy(busy), .done(done), .pass(pass),
    .captured(captured), .mismatch_cnt(mismatch_cnt), .fail_valid(fail_valid),
    .first_fail(first_fail)
  );

  truth_table_checker #(.N_IN(4), .SETTLE_CYC(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .expected(expected4),
    .vec_out(vec4), .y_in(y4), .busy(busy4), .done(done4), .pass(pass4),
    .captured(captured4), .mismatch_cnt(mismatch_cnt4), .fail_valid(fail_valid4),
    .first_fail(first_fail4)
  );

  typedef struct {
    logic [15:0] cap;
    int          cnt;
    logic        fv;
    int          ff;
    logic        pass;
  } res_t;

  res_t q3[$];
  res_t q4[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference tables straight from the boolean definitions.
  function automatic logic [7:0] golden3();
    logic [7:0] t;
    for (int v = 0; v < 8; v++) begin
      int a, b, c;
      a = (v >> 2) & 1; b = (v >> 1) & 1; c = v & 1;
      t[v] = ((a & b) | (1 - c)) != 0;
    end
    return t;
  endfunction

  function automatic logic [15:0] parity4();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = $countones(v[3:0]) % 2 == 1;
    return t;
  endfunction

  function automatic res_t model(input logic [15:0] f, input logic [15:0] e, input int nb);
    res_t r;
    r.cap = '0; r.cnt = 0; r.fv = 1'b0; r.ff = 0;
    for (int i = 0; i < (1 << nb); i++) begin
      r.cap[i] = f[i];
      if (f[i] != e[i]) begin
        r.cnt++;
        if (!r.fv) begin r.fv = 1'b1; r.ff = i; end
      end
    end
    r.pass = (r.cnt == 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q3.size() == 0) chk("dut3_unexpected_done", 32'd1, 32'd0);
      else begin
        res_t r;
        r = q3.pop_front();
        chk("dut3_captured", {24'd0, captured}, {16'd0, r.cap});
        chk("dut3_mismatch_cnt", {28'd0, mismatch_cnt}, r.cnt);
        chk("dut3_fail_valid", {31'd0, fail_valid}, {31'd0, r.fv});
        if (r.fv) chk("dut3_first_fail", {29'd0, first_fail}, r.ff);
        chk("dut3_pass", {31'd0, pass}, {31'd0, r.pass});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) chk("dut4_unexpected_done", 32'd1, 32'd0);
      else begin
        res_t r;
        r = q4.pop_front();
        chk("dut4_captured", {16'd0, captured4}, {16'd0, r.cap});
        chk("dut4_mismatch_cnt", {27'd0, mismatch_cnt4}, r.cnt);
        chk("dut4_fail_valid", {31'd0, fail_valid4}, {31'd0, r.fv});
        if (r.fv) chk("dut4_first_fail", {28'd0, first_fail4}, r.ff);
        chk("dut4_pass", {31'd0, pass4}, {31'd0, r.pass});
      end
    end
  end

  task automatic wait_done(input bit sel4, input int lat, input string name);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk); n++; #1;
      if (sel4 ? done4 : done) seen = 1'b1;
    end
    chk({name, "_latency"}, seen ? n : -1, lat);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {31'd0, sel4 ? done4 : done}, 32'd0);
    chk({name, "_busy_after"}, {31'd0, sel4 ? busy4 : busy}, 32'd0);
  endtask

  task automatic run3(input logic [7:0] e, input bit with_abort, input string name);
    logic [7:0] f;
    f = use_rand ? rand_tt : golden3();
    expected = e; start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    q3.push_back(model({8'd0, f}, {8'd0, e}, 3));
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(1'b0, 24, name);
  endtask

  task automatic idle_no_done(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk({name, "_no_done"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0;
    start4 = 1'b0; abort4 = 1'b0; expected4 = '0;
    use_rand = 1'b0; rand_tt = '0;
    #12;
    chk("reset_outputs", {10'd0, vec_out, busy, done, pass, captured, mismatch_cnt, fail_valid, first_fail}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run3(8'hD5, 1'b0, "match");
    run3(8'hD4, 1'b0, "first_vec_err");
    run3(8'h55, 1'b0, "last_vec_err");
    run3(8'h2A, 1'b0, "all_wrong");
    run3(8'hD5, 1'b1, "start_beats_abort");

    // Abort mid-sweep, then confirm a fresh sweep still completes.
    expected = 8'hD5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    idle_no_done(40, "abort");
    run3(8'hD5, 1'b0, "after_abort");

    // A second start mid-sweep must not replace the latched mask.
    expected = 8'hD5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    q3.push_back(model({8'd0, golden3()}, 16'h00D5, 3));
    repeat (10) @(posedge clk);
    #1 expected = 8'h2A; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0, 13, "restart_ignored");

    // Reset mid-sweep.
    expected = 8'hD5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midsweep_reset", {10'd0, vec_out, busy, done, pass, captured, mismatch_cnt, fail_valid, first_fail}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_no_done(40, "reset");

    use_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      rand_tt = 8'($urandom);
      e = ($urandom_range(0, 2) == 0) ? rand_tt : 8'($urandom);
      run3(e, 1'b0, "random");
    end
    use_rand = 1'b0;

    foreach (q4[i]) ;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] e;
      e = (i == 0) ? 16'h6996 : 16'($urandom);
      expected4 = e; start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      q4.push_back(model(parity4(), e, 4));
      wait_done(1'b1, 32, "xor4");
    end

    repeat (4) @(posedge clk);
    chk("queues_drained", q3.size() + q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
